// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte type and default FIFO geometry.
package uart_pkg;
    typedef logic [7:0] byte_t;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FIFO_CW    = $clog2(UART_FIFO_DEPTH) + 1;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Push/pop/status bundle between the UART receiver, the RX FIFO and the packet consumer.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  full, dout, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output full, dout, empty, count, overflow, underflow
    );
endinterface

// File: rtl/uart_rx_fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read-first read with a held output register.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX byte FIFO with sticky overflow/underflow flags.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave fifo
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             empty_nxt_s;
    logic             overflow_r;
    logic             underflow_r;
    logic             push_acc_s;
    logic             pop_acc_s;
    logic             ram_re_s;
    logic [WIDTH-1:0] ram_rdata_s;

    uart_fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_acc_s),
        .waddr (wr_ptr_r),
        .wdata (fifo.din),
        .re    (ram_re_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

`ifdef UART_RX_FIFO_FWFT_EN
    logic          valid_r;
    logic          valid_nxt_s;
    logic [CW-1:0] ram_cnt_s;

    // The RAM read register is the head slot; refill it whenever it is free or being consumed.
    always_comb begin
        pop_acc_s   = fifo.rd_en && valid_r;
        push_acc_s  = fifo.wr_en && (!full_r || pop_acc_s);
        ram_cnt_s   = count_r - {{(CW-1){1'b0}}, valid_r};
        ram_re_s    = (ram_cnt_s != {CW{1'b0}}) && (!valid_r || pop_acc_s);
        valid_nxt_s = valid_r;
        if (ram_re_s) begin
            valid_nxt_s = 1'b1;
        end else if (pop_acc_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
        empty_nxt_s = !valid_nxt_s;
    end

    // Head-slot valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end
`else
    // Standard mode: a pop reads the RAM directly into the output register.
    always_comb begin
        pop_acc_s   = fifo.rd_en && !empty_r;
        push_acc_s  = fifo.wr_en && (!full_r || pop_acc_s);
        ram_re_s    = pop_acc_s;
        empty_nxt_s = (count_nxt_s == {CW{1'b0}});
    end
`endif

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, status and sticky error flags; a new error beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (ram_re_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == CW'(DEPTH));
            empty_r     <= empty_nxt_s;
            overflow_r  <= (fifo.wr_en && !push_acc_s) || (overflow_r && !fifo.clr_err);
            underflow_r <= (fifo.rd_en && !pop_acc_s) || (underflow_r && !fifo.clr_err);
        end
    end

    assign fifo.dout      = ram_rdata_s;
    assign fifo.full      = full_r;
    assign fifo.empty     = empty_r;
    assign fifo.count     = count_r;
    assign fifo.overflow  = overflow_r;
    assign fifo.underflow = underflow_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model (both output modes).
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    byte_t q[$];
    byte_t exp_dout = 8'h00;
    bit    exp_ovf = 1'b0;
    bit    exp_udf = 1'b0;
    bit    shown = 1'b0;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(8)) fifo_if ();

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (fifo_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("count", 32'(fifo_if.count), 32'(q.size()));
        check_val("full", 32'(fifo_if.full), 32'(q.size() == DEPTH));
        check_val("overflow", 32'(fifo_if.overflow), 32'(exp_ovf));
        check_val("underflow", 32'(fifo_if.underflow), 32'(exp_udf));
`ifdef UART_RX_FIFO_FWFT_EN
        check_val("empty", 32'(fifo_if.empty), 32'(!shown));
        if (shown) check_val("dout_head", 32'(fifo_if.dout), 32'(q[0]));
`else
        check_val("empty", 32'(fifo_if.empty), 32'(q.size() == 0));
        check_val("dout", 32'(fifo_if.dout), 32'(exp_dout));
`endif
    endtask

    // One clock with the given inputs; the model advances by the spec's accept rules.
    task automatic step(input bit wr, input byte_t d, input bit rd, input bit clr);
        bit pop;
        bit push;
        int pre;
        bit was_shown;
        fifo_if.wr_en   = wr;
        fifo_if.din     = d;
        fifo_if.rd_en   = rd;
        fifo_if.clr_err = clr;
        pre       = q.size();
        was_shown = shown;
`ifdef UART_RX_FIFO_FWFT_EN
        pop = rd && shown;
`else
        pop = rd && (pre != 0);
`endif
        push = wr && ((pre != DEPTH) || pop);
        if (pop) exp_dout = q.pop_front();
        if (push) q.push_back(d);
        exp_ovf = (wr && !push) || (exp_ovf && !clr);
        exp_udf = (rd && !pop) || (exp_udf && !clr);
        // A stored byte reaches the head one edge after it sits behind a free head slot.
        if (was_shown && !pop) shown = 1'b1;
        else shown = (pre - int'(was_shown)) > 0;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input bit wr, input bit rd);
        rst             = 1'b1;
        fifo_if.wr_en   = wr;
        fifo_if.din     = 8'hEE;
        fifo_if.rd_en   = rd;
        fifo_if.clr_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        shown    = 1'b0;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        fifo_if.wr_en   = 1'b0;
        fifo_if.din     = 8'h00;
        fifo_if.rd_en   = 1'b0;
        fifo_if.clr_err = 1'b0;
        do_reset(1'b0, 1'b0);

        // Basic ordering.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow after reset, then clear.
        do_reset(1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_val("udf_cleared", 32'(fifo_if.underflow), 32'd0);

        // Fill, overflow, then simultaneous push/pop while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, byte_t'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 8'hA6, 1'b1, 1'b0);
        drain();

        // Sustained push+pop with incrementing data to wrap the pointers.
        step(1'b1, 8'h80, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, byte_t'(8'h81 + i), 1'b1, 1'b0);
        drain();

        // Push into empty: head visibility / latency.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Simultaneous push and pop while empty.
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with varying push/pop bias.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 9) < 3 + 2 * bias),
                 byte_t'($urandom),
                 ($urandom_range(0, 9) < 7 - 2 * bias),
                 ($urandom_range(0, 19) == 0));
        end

        // Reset mid-operation with push and pop pending.
        for (int i = 0; i < 5; i++) step(1'b1, byte_t'(8'hC0 + i), 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synchronous byte FIFO that sits directly downstream of the UART receiver. It absorbs bytes pushed on the receiver's `wr_en`/`dout` strobe and presents them to the packet consumer through a `rd_en`/`empty` pop interface. It exports `full` back to the UART top for flow control. It also latches sticky overflow and underflow error flags for the host status register.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, minimum 4.
- `WIDTH`, 8: data width in bits.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: push strobe from the receiver; one byte per asserted cycle.
- `din` in WIDTH: byte to push; sampled when `wr_en` is high.
- `full` out 1: no free entry; a push is accepted only if `!full`, or if a pop happens in the same cycle.
- `rd_en` in 1: pop request from the consumer.
- `dout` out WIDTH: popped byte (standard mode) or head byte (FWFT mode).
- `empty` out 1: no byte is available to pop.
- `count` out $clog2(DEPTH)+1: number of stored bytes, 0..DEPTH.
- `overflow` out 1: sticky; set by a push that was rejected.
- `underflow` out 1: sticky; set by a pop that was rejected.
- `clr_err` in 1: clears both sticky flags.

## Operation
- Storage is DEPTH entries addressed by `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH with no special case.
- `count` is the only occupancy state.
  - `full = (count == DEPTH)`.
  - In standard mode, `empty = (count == 0)`.
- Push accepted = `wr_en && (!full || pop_accepted)`. An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop accepted = `rd_en && !empty`. An accepted pop increments `rd_ptr`.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Rejected push (`wr_en && !push_accepted`): data is dropped, memory and pointers are untouched, `overflow` is set.
- Rejected pop (`rd_en && empty`): `dout` holds its value, `underflow` is set.
- Simultaneous push and pop while empty: the push is accepted, the pop is rejected, `underflow` is set, and `count` becomes 1.
- Simultaneous push and pop while full: both are accepted and `count` stays DEPTH.
- `clr_err` clears both flags. If a new error occurs in the same cycle as `clr_err`, the set wins.
- Memory contents are not reset.

## Timing
- Reset values: `count`=0, `wr_ptr`=`rd_ptr`=0, `empty`=1, `full`=0, `dout`=0, `overflow`=0, `underflow`=0.
- Reset asserted mid-operation discards all stored bytes on that edge. Any push or pop in the same cycle is ignored.
- `full`, `empty` and `count` are registered. They reflect a push or pop sampled at edge N right after edge N.
- Standard mode:
  - `dout` is registered.
  - The byte popped at edge N is valid on `dout` after edge N and held until the next accepted pop.
  - Read latency is 1 cycle.
- Maximum throughput is one push and one pop per cycle, sustained.

## Configuration
- Macro `UART_RX_FIFO_FWFT_EN`.
- Without the macro: standard mode as described above.
- With the macro: first-word-fall-through mode.
  - An output register holds the head byte, and `empty` is low whenever that register is valid.
  - `dout` shows the head byte without a read; `rd_en` acknowledges and consumes it.
  - A push into a totally empty FIFO at edge N makes `dout` valid and drops `empty` after edge N+1 (one prefetch cycle).
  - After a pop, the next stored byte is on `dout` in the following cycle, so back-to-back pops sustain one per cycle.
  - `count` includes the byte held in the output register. `full` is still `count == DEPTH`.

## Structure
- Shared package `uart_pkg` holds:
  - the `byte_t` typedef (`logic [7:0]`);
  - constants `UART_FIFO_DEPTH` = 16, the default handed to `DEPTH`;
  - `UART_FIFO_CW` = $clog2(UART_FIFO_DEPTH)+1, the width of `count`.
- One sub-module, `uart_fifo_ram`: a simple dual-port RAM with one synchronous write port and one synchronous read port, sized DEPTH×WIDTH. Pointer, count, flag and FWFT logic stay in `uart_rx_fifo`.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times. Required: `dout` = 0x11, 0x22, 0x33 (standard mode: 1 cycle after each `rd_en`); `count` goes 3→0; `empty` ends at 1.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0xFF. Required: `full`=1 after the 16th push, `overflow`=1, `count`=16; popping returns 0x00..0x0F and never 0xFF.
- Pop on an empty FIFO after reset. Required: `underflow`=1, `dout` stays 0x00, `count`=0. Then pulse `clr_err`: `underflow`=0 the next cycle.
- With the FIFO full, push 0xA5 and pop in the same cycle. Required: both accepted, `count` stays 16, `overflow` stays 0; 0xA5 is the last byte drained.
- Push and pop together every cycle for 40 cycles with incrementing data. Required: pointers wrap at least twice and the data comes out in order with no loss.
- With `UART_RX_FIFO_FWFT_EN`, push 0x5A into an empty FIFO. Required: `empty`=0 and `dout`=0x5A two edges after the push, with no `rd_en`; `rd_en` then returns `empty` to 1.
